training_sample_feeder: RTL and testbench

Upstream stage of the neuron training unit. Holds a small training set of (x1, x2, target) samples loaded by the host, then drives the neuron's X1/X2/target/count buses. It raises the neuron's start and presents samples in order each time the neuron signals it is ready for data, wrapping to sample 0 at the end of every epoch until the neuron reports done. It also counts completed epochs and reports completion back to the host.

---
 rtl/training_sample_feeder.sv | 172 +++++++++++++++++
 tb/tb_training_sample_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/training_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : training_sample_feeder
// Purpose  : Holds a host-loaded training set of (x1, x2, target) samples and
//            presents them in order to the neuron training unit, advancing one
//            sample per cycle the neuron reports ready. Wraps to sample 0 at
//            the end of every epoch until the neuron reports done, counting
//            completed epochs along the way.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            wr_en/wr_addr/
//            wr_x1/wr_x2/wr_t  - host write port into the sample buffer
//            n_samples, go     - host start request with sample count
//            nrn_ready/done    - neuron handshake inputs
//            nrn_start         - one-cycle start pulse to the neuron
//            x1/x2/t/n_bus     - registered sample buses to the neuron
//            busy, finished    - training status (finished is sticky)
//            err               - one-cycle pulse when a go is rejected
//            epoch_count       - completed epochs, saturating
// Revision : 1.0 - initial release
// ============================================================================
module training_sample_feeder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_x1,
    input  logic [6:0]    wr_x2,
    input  logic [1:0]    wr_t,
    input  logic [AW:0]   n_samples,
    input  logic          go,
    input  logic          nrn_ready,
    input  logic          nrn_done,
    output logic          nrn_start,
    output logic [6:0]    x1_bus,
    output logic [6:0]    x2_bus,
    output logic [1:0]    t_bus,
    output logic [31:0]   n_bus,
    output logic          busy,
    output logic          finished,
    output logic          err,
    output logic [15:0]   epoch_count
);

    localparam logic [1:0]    c_IDLE      = 2'd0;
    localparam logic [1:0]    c_START     = 2'd1;
    localparam logic [1:0]    c_FEED      = 2'd2;
    localparam logic [1:0]    c_FINISH    = 2'd3;

    localparam logic [AW:0]   c_DEPTH_N   = DEPTH[AW:0];
    localparam logic [AW:0]   c_ONE_N     = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_ONE_A     = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]   c_EPOCH_MAX = 16'hFFFF;

    // Sample word layout: {x1[6:0], x2[6:0], t[1:0]}
    logic [15:0]   r_mem [DEPTH];

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW:0]   r_n;
    logic [6:0]    r_x1;
    logic [6:0]    r_x2;
    logic [1:0]    r_t;
    logic [15:0]   r_epoch;
    logic          r_err;

    logic          w_host_phase;
    logic          w_n_ok;
    logic          w_go_acc;
    logic          w_go_rej;
    logic          w_adv;
    logic          w_last;
    logic [AW:0]   w_n_m1;
    logic [AW-1:0] w_idx_nxt;
    logic [15:0]   w_rd_word;
    logic [15:0]   w_mem0;

    // The host owns the buffer only while the neuron is not being fed.
    assign w_host_phase = (r_state == c_IDLE) || (r_state == c_FINISH);
    assign w_n_ok       = (n_samples != '0) && (n_samples <= c_DEPTH_N);
    assign w_go_acc     = go && w_host_phase && w_n_ok;
    assign w_go_rej     = go && w_host_phase && !w_n_ok;

    // Done wins over ready: no advance on the cycle that ends training.
    assign w_adv        = (r_state == c_FEED) && nrn_ready && !nrn_done;
    assign w_n_m1       = r_n - c_ONE_N;
    assign w_last       = ({1'b0, r_idx} == w_n_m1);
    assign w_idx_nxt    = w_last ? '0 : (r_idx + c_ONE_A);
    assign w_rd_word    = r_mem[w_idx_nxt];
    assign w_mem0       = r_mem[0];

    // Sample buffer: no reset so the training set survives an abort.
    always_ff @(posedge clk) begin
        if (wr_en && w_host_phase) begin
            r_mem[wr_addr] <= {wr_x1, wr_x2, wr_t};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        nrn_start   = 1'b0;
        busy        = 1'b0;
        finished    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_go_acc) w_state_nxt = c_START;
            end
            c_START: begin
                nrn_start   = 1'b1;
                busy        = 1'b1;
                w_state_nxt = c_FEED;
            end
            c_FEED: begin
                busy = 1'b1;
                if (nrn_done) w_state_nxt = c_FINISH;
            end
            c_FINISH: begin
                finished = 1'b1;
                if (w_go_acc) w_state_nxt = c_START;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath. The go preload reads address 0 through the non-blocking
    // memory update, so a same-cycle host write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_n     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_t     <= '0;
            r_epoch <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_go_rej;
            if (w_go_acc) begin
                r_n                <= n_samples;
                r_epoch            <= '0;
                r_idx              <= '0;
                {r_x1, r_x2, r_t}  <= w_mem0;
            end else if (w_adv) begin
                r_idx              <= w_idx_nxt;
                {r_x1, r_x2, r_t}  <= w_rd_word;
                if (w_last && (r_epoch != c_EPOCH_MAX)) begin
                    r_epoch <= r_epoch + 16'd1;
                end
            end
        end
    end

    assign x1_bus      = r_x1;
    assign x2_bus      = r_x2;
    assign t_bus       = r_t;
    assign n_bus       = {{(32-AW-1){1'b0}}, r_n};
    assign err         = r_err;
    assign epoch_count = r_epoch;

endmodule
`default_nettype wire

// File: tb/tb_training_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_training_sample_feeder
// Purpose  : Directed bench for training_sample_feeder with a reference
//            model of the sample feeder checked against the DUT every cycle,
//            plus literal expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_training_sample_feeder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_x1;
    logic [6:0]    wr_x2;
    logic [1:0]    wr_t;
    logic [AW:0]   n_samples;
    logic          go;
    logic          nrn_ready;
    logic          nrn_done;
    logic          nrn_start;
    logic [6:0]    x1_bus;
    logic [6:0]    x2_bus;
    logic [1:0]    t_bus;
    logic [31:0]   n_bus;
    logic          busy;
    logic          finished;
    logic          err;
    logic [15:0]   epoch_count;

    training_sample_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_x1      (wr_x1),
        .wr_x2      (wr_x2),
        .wr_t       (wr_t),
        .n_samples  (n_samples),
        .go         (go),
        .nrn_ready  (nrn_ready),
        .nrn_done   (nrn_done),
        .nrn_start  (nrn_start),
        .x1_bus     (x1_bus),
        .x2_bus     (x2_bus),
        .t_bus      (t_bus),
        .n_bus      (n_bus),
        .busy       (busy),
        .finished   (finished),
        .err        (err),
        .epoch_count(epoch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase of the training session as the host sees it.
    localparam int P_IDLE = 0, P_START = 1, P_FEED = 2, P_DONE = 3;

    int          m_phase = P_IDLE;
    bit          m_valid = 1'b0;
    logic [15:0] m_mem [DEPTH];
    int          m_n   = 0;
    int          m_pos = 0;
    int          m_ep  = 0;
    bit          m_err = 1'b0;
    logic [15:0] m_cur = 16'h0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
    end

    always @(posedge clk) begin : model
        logic [15:0] old0;
        bit          host;
        bit          ok;
        if (rst) begin
            m_phase = P_IDLE; m_n = 0; m_pos = 0; m_ep = 0;
            m_err = 1'b0; m_cur = 16'h0; m_valid = 1'b1;
        end else if (m_valid) begin
            old0 = m_mem[0];
            host = (m_phase == P_IDLE) || (m_phase == P_DONE);
            ok   = (int'(n_samples) >= 1) && (int'(n_samples) <= DEPTH);
            m_err = go && host && !ok;
            if (wr_en && host) m_mem[wr_addr] = {wr_x1, wr_x2, wr_t};
            if (host) begin
                if (go && ok) begin
                    m_n = int'(n_samples); m_ep = 0; m_pos = 0;
                    m_cur = old0; m_phase = P_START;
                end
            end else if (m_phase == P_START) begin
                m_phase = P_FEED;
            end else begin
                if (nrn_done) begin
                    m_phase = P_DONE;
                end else if (nrn_ready) begin
                    m_pos = (m_pos + 1) % m_n;
                    if (m_pos == 0 && m_ep < 65535) m_ep++;
                    m_cur = m_mem[m_pos];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("nrn_start", {31'd0, nrn_start}, {31'd0, m_phase == P_START});
            chk("busy", {31'd0, busy}, {31'd0, (m_phase == P_START) || (m_phase == P_FEED)});
            chk("finished", {31'd0, finished}, {31'd0, m_phase == P_DONE});
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("x1_bus", {25'd0, x1_bus}, {25'd0, m_cur[15:9]});
            chk("x2_bus", {25'd0, x2_bus}, {25'd0, m_cur[8:2]});
            chk("t_bus", {30'd0, t_bus}, {30'd0, m_cur[1:0]});
            chk("n_bus", n_bus, m_n);
            chk("epoch_count", {16'd0, epoch_count}, m_ep);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int x1, input int x2, input int t);
        logic [31:0] v1, v2, vt;
        v1 = x1; v2 = x2; vt = t;
        wr_en = 1'b1; wr_addr = a[AW-1:0];
        wr_x1 = v1[6:0]; wr_x2 = v2[6:0]; wr_t = vt[1:0];
        cyc();
        wr_en = 1'b0;
    endtask

    function automatic logic [31:0] s7(input int v);
        logic [31:0] t;
        t = v;
        return {25'd0, t[6:0]};
    endfunction

    int seq [10] = '{3, -5, 0, 7, 3, -5, 0, 7, 3, -5};

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0;
        wr_t = '0; n_samples = '0; go = 1'b0; nrn_ready = 1'b0; nrn_done = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset n_bus", n_bus, 32'd0);
        chk("reset x1", {25'd0, x1_bus}, 32'd0);

        wr(0, 3, -2, 1); wr(1, -5, 6, 2); wr(2, 0, 1, 1); wr(3, 7, -7, 2);

        // Accepted go: start pulse, preloaded buses.
        n_samples = 7'd4; go = 1'b1; cyc(); go = 1'b0;
        chk("start pulse", {31'd0, nrn_start}, 32'd1);
        chk("n_bus latched", n_bus, 32'd4);
        chk("preload x1", {25'd0, x1_bus}, s7(3));
        chk("preload x2", {25'd0, x2_bus}, s7(-2));
        cyc();
        chk("start one cycle", {31'd0, nrn_start}, 32'd0);

        // Ten consecutive ready cycles.
        nrn_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("x1 seq %0d", i), {25'd0, x1_bus}, s7(seq[i]));
            cyc();
        end
        chk("epochs after 10", {16'd0, epoch_count}, 32'd2);
        cyc();                                  // now at idx 3
        chk("x1 at idx3", {25'd0, x1_bus}, s7(7));
        nrn_done = 1'b1; cyc(); nrn_done = 1'b0; nrn_ready = 1'b0;
        chk("done finished", {31'd0, finished}, 32'd1);
        chk("done busy", {31'd0, busy}, 32'd0);
        chk("done no advance", {25'd0, x1_bus}, s7(7));
        chk("done epoch held", {16'd0, epoch_count}, 32'd2);

        // Rejected go in FINISH.
        n_samples = 7'd0; go = 1'b1; cyc(); go = 1'b0;
        chk("err in finish", {31'd0, err}, 32'd1);
        chk("still finished", {31'd0, finished}, 32'd1);

        // Rejected go in IDLE, both boundaries.
        rst = 1'b1; cyc(); rst = 1'b0;
        n_samples = 7'd0; go = 1'b1; cyc(); go = 1'b0;
        chk("err n=0", {31'd0, err}, 32'd1);
        cyc();
        chk("err one cycle", {31'd0, err}, 32'd0);
        n_samples = 7'd65; go = 1'b1; cyc(); go = 1'b0;
        chk("err n=65", {31'd0, err}, 32'd1);
        chk("no start on err", {31'd0, nrn_start}, 32'd0);
        cyc();

        // Reset mid-feed, then restart without reloading.
        n_samples = 7'd4; go = 1'b1; cyc(); go = 1'b0; cyc();
        nrn_ready = 1'b1; cyc(); cyc(); nrn_ready = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort x1", {25'd0, x1_bus}, 32'd0);
        chk("abort epoch", {16'd0, epoch_count}, 32'd0);
        chk("abort n_bus", n_bus, 32'd0);
        n_samples = 7'd4; go = 1'b1; cyc(); go = 1'b0; cyc();
        chk("retained x1", {25'd0, x1_bus}, s7(3));

        // Host write during FEED is ignored.
        nrn_ready = 1'b1;
        wr(0, 9, 9, 3);
        cyc(); cyc(); cyc();
        nrn_ready = 1'b0;
        chk("feed write ignored", {25'd0, x1_bus}, s7(3));
        chk("one epoch", {16'd0, epoch_count}, 32'd1);
        nrn_done = 1'b1; cyc(); nrn_done = 1'b0;

        // Write and go together: preload sees pre-write data.
        wr_en = 1'b1; wr_addr = '0; wr_x1 = 7'd5; wr_x2 = 7'd5; wr_t = 2'd1;
        n_samples = 7'd2; go = 1'b1; cyc(); go = 1'b0; wr_en = 1'b0;
        chk("preload old data", {25'd0, x1_bus}, s7(3));
        cyc();
        nrn_ready = 1'b1; cyc();
        chk("n=2 second", {25'd0, x1_bus}, s7(-5));
        cyc(); nrn_ready = 1'b0;
        chk("new data after wrap", {25'd0, x1_bus}, s7(5));
        nrn_done = 1'b1; cyc(); nrn_done = 1'b0;

        // n = 1: every consume is an epoch.
        n_samples = 7'd1; go = 1'b1; cyc(); go = 1'b0; cyc();
        nrn_ready = 1'b1;
        repeat (5) cyc();
        nrn_ready = 1'b0;
        chk("n=1 epochs", {16'd0, epoch_count}, 32'd5);
        chk("n=1 bus steady", {25'd0, x1_bus}, s7(5));
        nrn_done = 1'b1; cyc(); nrn_done = 1'b0;

        // n = DEPTH: fill the whole buffer and wrap at 63.
        for (int i = 0; i < DEPTH; i++) wr(i, i, -i, i % 4);
        n_samples = 7'd64; go = 1'b1; cyc(); go = 1'b0; cyc();
        nrn_ready = 1'b1;
        repeat (63) cyc();
        chk("idx 63", {25'd0, x1_bus}, s7(63));
        chk("no epoch yet", {16'd0, epoch_count}, 32'd0);
        repeat (3) cyc();
        nrn_ready = 1'b0;
        chk("wrap to 2", {25'd0, x1_bus}, s7(2));
        chk("depth epoch", {16'd0, epoch_count}, 32'd1);
        nrn_done = 1'b1; cyc(); nrn_done = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
